// File: rtl/san_cnt_multi_pkg.sv
// Shared register map, CTRL bit positions, ID word and channel state type for
// the multi-channel down-counter block.
package san_cnt_pkg;

  localparam int unsigned IDX_STATUS   = 32'd0;
  localparam int unsigned IDX_MASK     = 32'd1;
  localparam int unsigned IDX_PRESCALE = 32'd2;
  localparam int unsigned IDX_ID       = 32'd3;
  localparam int unsigned CH_BASE      = 32'd4;
  localparam int unsigned OFF_CTRL     = 32'd0;
  localparam int unsigned OFF_LOAD     = 32'd1;
  localparam int unsigned OFF_COUNT    = 32'd2;

  localparam int unsigned CTRL_EN    = 32'd0;
  localparam int unsigned CTRL_AUTO  = 32'd1;
  localparam int unsigned CTRL_START = 32'd2;

  localparam logic [31:0] ID_VALUE = 32'h5343_0100;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_t;

  // Word index of register 'off' inside channel 'ch'.
  function automatic int unsigned chan_reg(input int unsigned ch, input int unsigned off);
    return CH_BASE * (ch + 32'd1) + off;
  endfunction

endpackage

// File: rtl/san_cnt_multi_if.sv
// Decoded register-access bus between the AXI-Lite slave shell and the
// counter block, plus the interrupt line back to the PS.
interface san_cnt_multi_if #(
  parameter int ADDR_W = 5
);
  logic              slv_reg_wren;
  logic [ADDR_W-1:0] axi_awaddr;
  logic [31:0]       S_AXI_WDATA;
  logic              slv_reg_rden;
  logic [ADDR_W-1:0] axi_araddr;
  logic [31:0]       reg_data_out;
  logic              EXT_IRQ;

  modport master (
    output slv_reg_wren, axi_awaddr, S_AXI_WDATA, slv_reg_rden, axi_araddr,
    input  reg_data_out, EXT_IRQ
  );

  modport slave (
    input  slv_reg_wren, axi_awaddr, S_AXI_WDATA, slv_reg_rden, axi_araddr,
    output reg_data_out, EXT_IRQ
  );
endinterface

// File: rtl/san_cnt_multi_chan.sv
// One down-counter channel: IDLE/RUN state, COUNT, LOAD and AUTO mode.
// 'expire' is high in the cycle whose clock edge flags the channel expiry.
module san_cnt_chan
  import san_cnt_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             ctrl_we,
  input  logic             load_we,
  input  logic [31:0]      wdata,
  output logic             en,
  output logic             auto_mode,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] load,
  output logic             expire
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  chan_state_t      state_r, state_nx;
  logic [CNT_W-1:0] count_r, count_nx;
  logic [CNT_W-1:0] load_r;
  logic             auto_r, auto_nx;
  logic             pend_r, pend_nx;

  // Channel registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      count_r <= CNT_ZERO;
      load_r  <= CNT_ZERO;
      auto_r  <= 1'b0;
      pend_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      count_r <= count_nx;
      auto_r  <= auto_nx;
      pend_r  <= pend_nx;
      if (load_we) begin
        load_r <= wdata[CNT_W-1:0];
      end
    end
  end

  // Next state; pend_r marks the tick after an auto-reload expiry, which
  // reloads LOAD (or expires again straight away when LOAD is 0)
  always_comb begin
    state_nx = state_r;
    count_nx = count_r;
    auto_nx  = auto_r;
    pend_nx  = pend_r;
    expire   = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (!tick) begin
          count_nx = count_r;
        end else if (pend_r && auto_r) begin
          if (load_r == CNT_ZERO) begin
            expire   = 1'b1;
            count_nx = CNT_ZERO;
          end else begin
            count_nx = load_r;
            pend_nx  = 1'b0;
          end
        end else if (count_r > CNT_ONE) begin
          count_nx = count_r - CNT_ONE;
        end else begin
          expire   = 1'b1;
          count_nx = CNT_ZERO;
          if (auto_r) begin
            pend_nx = 1'b1;
          end else begin
            pend_nx  = 1'b0;
            state_nx = ST_IDLE;
          end
        end
      end
      ST_IDLE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    // A CTRL write overrides EN/START; a plain EN write freezes or resumes COUNT
    if (ctrl_we) begin
      auto_nx  = wdata[CTRL_AUTO];
      state_nx = wdata[CTRL_EN] ? ST_RUN : ST_IDLE;
      if (wdata[CTRL_START]) begin
        count_nx = load_r;
        pend_nx  = 1'b0;
      end else if (!expire) begin
        count_nx = count_r;
        pend_nx  = pend_r;
      end else begin
        count_nx = CNT_ZERO;
      end
    end else begin
      auto_nx = auto_r;
    end
  end

  assign en        = (state_r == ST_RUN);
  assign auto_mode = auto_r;
  assign count     = count_r;
  assign load      = load_r;

endmodule

// File: rtl/san_cnt_multi.sv
// N_CH down-counters behind a decoded AXI-Lite register slice with sticky
// expiry flags and a masked, registered interrupt. Macro SAN_CNT_PRESCALE_EN adds a shared tick prescaler.
module san_cnt_multi
  import san_cnt_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 5
) (
  input  logic          S_AXI_ACLK,
  input  logic          S_AXI_ARESET,
  san_cnt_multi_if.slave bus
);

  logic [N_CH-1:0]  status_r, mask_r, w1c_s;
  logic [N_CH-1:0]  ctrl_we_s, load_we_s, expire_s, en_s, auto_s;
  logic [CNT_W-1:0] count_s [N_CH];
  logic [CNT_W-1:0] load_s  [N_CH];
  logic             wr_status_s, wr_mask_s, tick_s, irq_r;
  logic [31:0]      prescale_rd_s, chan_rd_s, rd_mux_s, rd_data_r;

  assign wr_status_s = bus.slv_reg_wren && (bus.axi_awaddr == ADDR_W'(IDX_STATUS));
  assign wr_mask_s   = bus.slv_reg_wren && (bus.axi_awaddr == ADDR_W'(IDX_MASK));
  assign w1c_s       = wr_status_s ? bus.S_AXI_WDATA[N_CH-1:0] : {N_CH{1'b0}};

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign ctrl_we_s[c] = bus.slv_reg_wren && (bus.axi_awaddr == ADDR_W'(chan_reg(c, OFF_CTRL)));
    assign load_we_s[c] = bus.slv_reg_wren && (bus.axi_awaddr == ADDR_W'(chan_reg(c, OFF_LOAD)));

    san_cnt_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk      (S_AXI_ACLK),
      .rst      (S_AXI_ARESET),
      .tick     (tick_s),
      .ctrl_we  (ctrl_we_s[c]),
      .load_we  (load_we_s[c]),
      .wdata    (bus.S_AXI_WDATA),
      .en       (en_s[c]),
      .auto_mode(auto_s[c]),
      .count    (count_s[c]),
      .load     (load_s[c]),
      .expire   (expire_s[c])
    );
  end

`ifdef SAN_CNT_PRESCALE_EN
  logic [7:0] prescale_r, pre_cnt_r;
  logic       wr_pre_s;

  assign wr_pre_s      = bus.slv_reg_wren && (bus.axi_awaddr == ADDR_W'(IDX_PRESCALE));
  assign tick_s        = (pre_cnt_r == prescale_r);
  assign prescale_rd_s = {24'h00_0000, prescale_r};

  // Shared prescaler, restarted by every PRESCALE write
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      prescale_r <= 8'h00;
      pre_cnt_r  <= 8'h00;
    end else if (wr_pre_s) begin
      prescale_r <= bus.S_AXI_WDATA[7:0];
      pre_cnt_r  <= 8'h00;
    end else if (tick_s) begin
      pre_cnt_r <= 8'h00;
    end else begin
      pre_cnt_r <= pre_cnt_r + 8'h01;
    end
  end
`else
  assign tick_s        = 1'b1;
  assign prescale_rd_s = 32'h0000_0000;
`endif

  // Sticky expiry flags (a same-cycle expiry beats the W1C clear), mask and IRQ
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      status_r <= {N_CH{1'b0}};
      mask_r   <= {N_CH{1'b0}};
      irq_r    <= 1'b0;
    end else begin
      status_r <= (status_r & ~w1c_s) | expire_s;
      irq_r    <= |(status_r & mask_r);
      if (wr_mask_s) begin
        mask_r <= bus.S_AXI_WDATA[N_CH-1:0];
      end
    end
  end

  // Channel register read-back; reserved and unmapped indices contribute 0
  always_comb begin
    chan_rd_s = 32'h0000_0000;
    for (int c = 0; c < N_CH; c++) begin
      chan_rd_s = chan_rd_s
        | ((bus.axi_araddr == ADDR_W'(chan_reg(c, OFF_CTRL)))
             ? {30'h0000_0000, auto_s[c], en_s[c]} : 32'h0000_0000)
        | ((bus.axi_araddr == ADDR_W'(chan_reg(c, OFF_LOAD)))
             ? 32'(load_s[c]) : 32'h0000_0000)
        | ((bus.axi_araddr == ADDR_W'(chan_reg(c, OFF_COUNT)))
             ? 32'(count_s[c]) : 32'h0000_0000);
    end
  end

  // Global register read-back
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (bus.axi_araddr)
      ADDR_W'(IDX_STATUS):   rd_mux_s = {{(32-N_CH){1'b0}}, status_r};
      ADDR_W'(IDX_MASK):     rd_mux_s = {{(32-N_CH){1'b0}}, mask_r};
      ADDR_W'(IDX_PRESCALE): rd_mux_s = prescale_rd_s;
      ADDR_W'(IDX_ID):       rd_mux_s = ID_VALUE;
      default:               rd_mux_s = chan_rd_s;
    endcase
  end

  // Read data holds until the next read strobe
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rd_data_r <= 32'h0000_0000;
    end else if (bus.slv_reg_rden) begin
      rd_data_r <= rd_mux_s;
    end
  end

  assign bus.reg_data_out = rd_data_r;
  assign bus.EXT_IRQ      = irq_r;

endmodule
